// File: rtl/pe_ctrl_seq_pkg.sv
// Shared constants for the PE control sequencer and the PE ctrl unpacking.
// Op codes, FSM state encoding and packed ctrl field offsets.
package pe_ctrl_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP = 3'd0;
  localparam logic [OP_W-1:0] OP_MUL = 3'd1;
  localparam logic [OP_W-1:0] OP_MAC = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COMP  = 3'd1,
    S_FLUSH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int OFF_OP       = 0;
  localparam int OFF_ENABLE   = 3;
  localparam int OFF_RD_REQ   = 4;
  localparam int OFF_WR_REQ   = 5;
  localparam int OFF_WR_VALID = 6;
  localparam int OFF_FLUSH    = 7;
  localparam int OFF_WR_ADDR  = 8;

  // Upper field offsets move with the buffer address width.
  function automatic int off_rd_addr(int aw);
    return OFF_WR_ADDR + aw;
  endfunction

  function automatic int off_pop(int aw);
    return OFF_WR_ADDR + 2 * aw;
  endfunction

  function automatic int off_push(int aw);
    return OFF_WR_ADDR + 2 * aw + 1;
  endfunction

endpackage

// File: rtl/pe_ctrl_seq_if.sv
// Scheduler <-> sequencer bundle: launch/config in, PE ctrl word and
// status out. Master = layer scheduler, slave = sequencer.
interface pe_ctrl_seq_if #(
  parameter int PE_BUF_ADDR_WIDTH = 10,
  parameter int OP_CODE_WIDTH     = 3,
  parameter int CNT_WIDTH         = 8,
  parameter int CTRL_WIDTH        = 2*PE_BUF_ADDR_WIDTH+10
);
  logic                         start;
  logic [CNT_WIDTH-1:0]         cfg_num_out;
  logic [CNT_WIDTH-1:0]         cfg_kernel_size;
  logic [PE_BUF_ADDR_WIDTH-1:0] cfg_rd_base;
  logic [PE_BUF_ADDR_WIDTH-1:0] cfg_wr_base;
  logic                         cfg_norm_en;
  logic                         ext_write_req;
  logic [CTRL_WIDTH-1:0]        ctrl;
  logic                         src_2_sel;
  logic                         busy;
  logic                         done;

  modport master (
    output start, cfg_num_out, cfg_kernel_size,
    output cfg_rd_base, cfg_wr_base, cfg_norm_en,
    output ext_write_req,
    input  ctrl, src_2_sel, busy, done
  );

  modport slave (
    input  start, cfg_num_out, cfg_kernel_size,
    input  cfg_rd_base, cfg_wr_base, cfg_norm_en,
    input  ext_write_req,
    output ctrl, src_2_sel, busy, done
  );
endinterface

// File: rtl/pe_ctrl_seq_counter.sv
// Loadable, enabled, wrapping up-counter with a terminal-count flag.
// Load has priority over enable.
module pe_ctrl_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             term
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign term = (count == last);

endmodule

// File: rtl/pe_ctrl_seq.sv
// PE control sequencer: N outputs x (K MAC reads, flush, write-back).
// Optional norm FIFO push enabled by defining PE_CTRL_NORM_EN.
module pe_ctrl_seq
  import pe_ctrl_pkg::*;
#(
  parameter int PE_BUF_ADDR_WIDTH = 10,
  parameter int OP_CODE_WIDTH     = 3,
  parameter int CNT_WIDTH         = 8,
  parameter int CTRL_WIDTH        = 2*PE_BUF_ADDR_WIDTH+10
) (
  input logic         clk,
  input logic         reset,
  pe_ctrl_seq_if.slave bus
);

  localparam int AW = PE_BUF_ADDR_WIDTH;
  localparam int CW = CNT_WIDTH;
  localparam int OW = OP_CODE_WIDTH;

  state_t          state;
  logic [CW-1:0]   n_q;
  logic [CW-1:0]   k_q;
  logic [AW-1:0]   wr_base_q;
  logic            norm_on;

  logic [CW-1:0]   tap_cnt;
  logic [CW-1:0]   out_cnt;
  logic [AW-1:0]   rd_ptr;
  logic            tap_term;
  logic            out_term;
  logic            rd_unused_term;

  logic is_idle, is_comp, is_flush, is_write, is_done;
  logic launch, stall, comp_go, write_go;

  assign is_idle  = (state == S_IDLE);
  assign is_comp  = (state == S_COMP);
  assign is_flush = (state == S_FLUSH);
  assign is_write = (state == S_WRITE);
  assign is_done  = (state == S_DONE);

  assign launch   = is_idle & bus.start;
  assign stall    = bus.ext_write_req
                  & (is_comp | is_flush | is_write);
  assign comp_go  = is_comp & ~stall;
  assign write_go = is_write & ~stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      n_q       <= '0;
      k_q       <= '0;
      wr_base_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            n_q       <= bus.cfg_num_out;
            k_q       <= (bus.cfg_kernel_size == '0)
                       ? CW'(1) : bus.cfg_kernel_size;
            wr_base_q <= bus.cfg_wr_base;
            state     <= (bus.cfg_num_out == '0)
                       ? S_DONE : S_COMP;
          end
        end
        S_COMP: begin
          if (comp_go && tap_term) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (!stall) state <= S_WRITE;
        end
        S_WRITE: begin
          if (write_go) begin
            state <= out_term ? S_DONE : S_COMP;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PE_CTRL_NORM_EN
  logic norm_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      norm_q <= 1'b0;
    end else if (launch) begin
      norm_q <= bus.cfg_norm_en;
    end
  end
  assign norm_on = norm_q;
`else
  logic cfg_norm_unused;
  assign cfg_norm_unused = bus.cfg_norm_en;
  assign norm_on = 1'b0;
`endif

  pe_ctrl_counter #(.WIDTH(CW)) u_tap (
    .clk      (clk),
    .reset    (reset),
    .load     (launch | (comp_go & tap_term)),
    .load_val ('0),
    .en       (comp_go),
    .last     (k_q - CW'(1)),
    .count    (tap_cnt),
    .term     (tap_term)
  );

  pe_ctrl_counter #(.WIDTH(CW)) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (launch),
    .load_val ('0),
    .en       (write_go),
    .last     (n_q - CW'(1)),
    .count    (out_cnt),
    .term     (out_term)
  );

  // Read pointer runs continuously across outputs; only wraps.
  pe_ctrl_counter #(.WIDTH(AW)) u_rd (
    .clk      (clk),
    .reset    (reset),
    .load     (launch),
    .load_val (bus.cfg_rd_base),
    .en       (comp_go),
    .last     ('0),
    .count    (rd_ptr),
    .term     (rd_unused_term)
  );

  logic [OW-1:0] op;
  logic          en, rd_req, wr_req, wv, fl, push, src2;
  logic [AW-1:0] rd_addr, wr_addr;

  always_comb begin
    op      = OW'(OP_NOP);
    en      = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    wv      = 1'b0;
    fl      = 1'b0;
    push    = 1'b0;
    src2    = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    unique case (1'b1)
      is_comp: begin
        en      = 1'b1;
        rd_req  = 1'b1;
        rd_addr = rd_ptr;
        src2    = (tap_cnt != '0);
        op      = src2 ? OW'(OP_MAC) : OW'(OP_MUL);
      end
      is_flush: fl = 1'b1;
      is_write: begin
        wv      = 1'b1;
        wr_req  = 1'b1;
        wr_addr = wr_base_q + AW'(out_cnt);
        push    = norm_on;
      end
      default: ;
    endcase
    // Host write owns the buffer: drop strobes, keep addr/op.
    if (stall) begin
      en     = 1'b0;
      rd_req = 1'b0;
      wr_req = 1'b0;
      wv     = 1'b0;
      fl     = 1'b0;
      push   = 1'b0;
    end
  end

  assign bus.ctrl = CTRL_WIDTH'({push, 1'b0, rd_addr, wr_addr,
                                 fl, wv, wr_req, rd_req, en, op});
  assign bus.src_2_sel = src2;
  assign bus.busy      = ~is_idle;
  assign bus.done      = is_done;

endmodule

// File: tb/tb_pe_ctrl_seq.sv
// Testbench for pe_ctrl_seq: per-cycle trace vs a loop-level model.
// Honours PE_CTRL_NORM_EN for the expected norm push.
module tb_pe_ctrl_seq;

`ifdef PE_CTRL_NORM_EN
  localparam bit NORM_ON = 1'b1;
`else
  localparam bit NORM_ON = 1'b0;
`endif

  localparam int MAXC = 512;
  // strobes cleared by a host write: en,rd,wr,wv,flush,push
  localparam logic [32:0] GATE = ~33'h0_2000_00F8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_ctrl_seq_if #(
    .PE_BUF_ADDR_WIDTH(10),
    .OP_CODE_WIDTH(3),
    .CNT_WIDTH(8)
  ) bus ();

  pe_ctrl_seq #(
    .PE_BUF_ADDR_WIDTH(10),
    .OP_CODE_WIDTH(3),
    .CNT_WIDTH(8),
    .CTRL_WIDTH(30)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit          stall_pat[MAXC];
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];

  // {busy, done, src2, push, pop, rd_addr, wr_addr,
  //  flush, wv, wr_req, rd_req, en, op}
  function automatic logic [32:0] mk(
    bit busy, bit dn, bit src2, bit push,
    logic [9:0] ra, logic [9:0] wa,
    bit fl, bit wv, bit wrq, bit rrq, bit en,
    logic [2:0] op);
    return {busy, dn, src2, push, 1'b0, ra, wa,
            fl, wv, wrq, rrq, en, op};
  endfunction

  task automatic clear_stall();
    for (int i = 0; i < MAXC; i++) stall_pat[i] = 1'b0;
  endtask

  task automatic build_model(input int n, input int k,
                             input logic [9:0] rd,
                             input logic [9:0] wr,
                             input bit norm);
    logic [32:0] steps[$];
    logic [9:0]  ptr;
    logic [9:0]  wa;
    int          kk;
    int          pos;
    steps = {};
    kk  = (k == 0) ? 1 : k;
    ptr = rd;
    for (int o = 0; o < n; o++) begin
      for (int t = 0; t < kk; t++) begin
        steps.push_back(mk(1, 0, t > 0, 0, ptr, 10'h0,
                           0, 0, 0, 1, 1,
                           (t == 0) ? 3'd1 : 3'd2));
        ptr = ptr + 10'd1;
      end
      steps.push_back(mk(1, 0, 0, 0, 10'h0, 10'h0,
                         1, 0, 0, 0, 0, 3'd0));
      wa = wr + 10'(o);
      steps.push_back(mk(1, 0, 0, norm && NORM_ON,
                         10'h0, wa, 0, 1, 1, 0, 0, 3'd0));
    end
    steps.push_back(mk(1, 1, 0, 0, 10'h0, 10'h0,
                       0, 0, 0, 0, 0, 3'd0));
    exp_q = {};
    pos = 0;
    for (int c = 0; c < MAXC - 2 && pos < steps.size(); c++) begin
      if (stall_pat[c] && !steps[pos][31]) begin
        exp_q.push_back(steps[pos] & GATE);
      end else begin
        exp_q.push_back(steps[pos]);
        pos++;
      end
    end
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic drive_pass(input int n, input int k,
                            input logic [9:0] rd,
                            input logic [9:0] wr,
                            input bit norm, input int poke);
    obs_q = {};
    @(negedge clk);
    bus.cfg_num_out     = 8'(n);
    bus.cfg_kernel_size = 8'(k);
    bus.cfg_rd_base     = rd;
    bus.cfg_wr_base     = wr;
    bus.cfg_norm_en     = norm;
    bus.ext_write_req   = 1'b0;
    bus.start           = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) @(negedge clk);
      bus.start = (c == poke);
      if (c == poke) begin
        bus.cfg_num_out     = 8'($urandom_range(1, 9));
        bus.cfg_kernel_size = 8'($urandom_range(1, 9));
        bus.cfg_rd_base     = 10'($urandom);
        bus.cfg_wr_base     = 10'($urandom);
        bus.cfg_norm_en     = ~norm;
      end
      bus.ext_write_req = stall_pat[c];
      #1;
      obs_q.push_back({bus.busy, bus.done,
                       bus.src_2_sel, bus.ctrl});
    end
    bus.start = 1'b0;
    bus.ext_write_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.ext_write_req = 1'b1;
    bus.cfg_num_out = 8'd2;
    bus.cfg_kernel_size = 8'd3;
    bus.cfg_rd_base = 10'h155;
    bus.cfg_wr_base = 10'h2AA;
    bus.cfg_norm_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.src_2_sel, bus.ctrl} !== 33'h0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want 0",
               {bus.busy, bus.done, bus.src_2_sel, bus.ctrl});
    end
    bus.start = 1'b0;
    bus.ext_write_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.src_2_sel, bus.ctrl} !== 33'h0) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want 0",
               {bus.busy, bus.done, bus.src_2_sel, bus.ctrl});
    end
  endtask

  task automatic test_basic();
    int busy_n, done_n, done_at;
    clear_stall();
    build_model(2, 3, 10'h010, 10'h200, 0);
    drive_pass(2, 3, 10'h010, 10'h200, 0, -1);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_cmp++;
      if (obs_q[c] !== exp_q[c]) begin
        n_bad++;
        $display("FAIL basic cyc %0d: got %h want %h",
                 c, obs_q[c], exp_q[c]);
      end
    end
    busy_n = 0; done_n = 0; done_at = -1;
    for (int c = 0; c < obs_q.size(); c++) begin
      if (obs_q[c][32]) busy_n++;
      if (obs_q[c][31]) begin
        done_n++;
        done_at = c + 1;
      end
    end
    n_cmp++;
    if (busy_n != 2 * (3 + 2) + 1) begin
      n_bad++;
      $display("FAIL basic_busy: got %0d want 11", busy_n);
    end
    n_cmp++;
    if (done_n != 1 || done_at != 11) begin
      n_bad++;
      $display("FAIL basic_done: got %0d@%0d want 1@11",
               done_n, done_at);
    end
  endtask

  task automatic test_stall();
    int busy_n;
    clear_stall();
    for (int i = 1; i <= 4; i++) stall_pat[i] = 1'b1;
    build_model(2, 3, 10'h010, 10'h200, 0);
    drive_pass(2, 3, 10'h010, 10'h200, 0, -1);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_cmp++;
      if (obs_q[c] !== exp_q[c]) begin
        n_bad++;
        $display("FAIL stall cyc %0d: got %h want %h",
                 c, obs_q[c], exp_q[c]);
      end
    end
    busy_n = 0;
    for (int c = 0; c < obs_q.size(); c++) begin
      if (obs_q[c][32] && !obs_q[c][31]) busy_n++;
    end
    n_cmp++;
    if (busy_n != 14) begin
      n_bad++;
      $display("FAIL stall_busy: got %0d want 14", busy_n);
    end
    clear_stall();
  endtask

  task automatic test_wrap();
    logic [9:0] want[4];
    logic [9:0] ra;
    want = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    clear_stall();
    build_model(1, 4, 10'h3FE, 10'h080, 0);
    drive_pass(1, 4, 10'h3FE, 10'h080, 0, -1);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_cmp++;
      if (obs_q[c] !== exp_q[c]) begin
        n_bad++;
        $display("FAIL wrap cyc %0d: got %h want %h",
                 c, obs_q[c], exp_q[c]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      ra = obs_q[i][27:18];
      n_cmp++;
      if (ra !== want[i]) begin
        n_bad++;
        $display("FAIL wrap_addr %0d: got %h want %h",
                 i, ra, want[i]);
      end
    end
  endtask

  task automatic test_n_zero();
    int reqs;
    clear_stall();
    build_model(0, 3, 10'h100, 10'h300, 0);
    drive_pass(0, 3, 10'h100, 10'h300, 0, -1);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_cmp++;
      if (obs_q[c] !== exp_q[c]) begin
        n_bad++;
        $display("FAIL n_zero cyc %0d: got %h want %h",
                 c, obs_q[c], exp_q[c]);
      end
    end
    n_cmp++;
    if (obs_q[0][31] !== 1'b1) begin
      n_bad++;
      $display("FAIL n_zero_done: got %b want 1", obs_q[0][31]);
    end
    reqs = 0;
    for (int c = 0; c < obs_q.size(); c++) begin
      if (obs_q[c][4] || obs_q[c][5]) reqs++;
    end
    n_cmp++;
    if (reqs != 0) begin
      n_bad++;
      $display("FAIL n_zero_req: got %0d want 0", reqs);
    end
  endtask

  task automatic test_k_zero();
    clear_stall();
    build_model(2, 0, 10'h020, 10'h040, 0);
    drive_pass(2, 0, 10'h020, 10'h040, 0, -1);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_cmp++;
      if (obs_q[c] !== exp_q[c]) begin
        n_bad++;
        $display("FAIL k_zero cyc %0d: got %h want %h",
                 c, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_norm();
    int pushes;
    clear_stall();
    build_model(3, 2, 10'h030, 10'h050, 1);
    drive_pass(3, 2, 10'h030, 10'h050, 1, -1);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_cmp++;
      if (obs_q[c] !== exp_q[c]) begin
        n_bad++;
        $display("FAIL norm cyc %0d: got %h want %h",
                 c, obs_q[c], exp_q[c]);
      end
    end
    pushes = 0;
    for (int c = 0; c < obs_q.size(); c++) begin
      if (obs_q[c][29]) pushes++;
    end
    n_cmp++;
    if (pushes != (NORM_ON ? 3 : 0)) begin
      n_bad++;
      $display("FAIL norm_push: got %0d want %0d",
               pushes, NORM_ON ? 3 : 0);
    end
  endtask

  task automatic test_reset_mid();
    clear_stall();
    @(negedge clk);
    bus.cfg_num_out = 8'd3;
    bus.cfg_kernel_size = 8'd4;
    bus.cfg_rd_base = 10'h0A0;
    bus.cfg_wr_base = 10'h1C0;
    bus.cfg_norm_en = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.ctrl} !== 31'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got %h want 0",
               {bus.busy, bus.ctrl});
    end
    @(negedge clk);
    rst_n = 1'b1;
    build_model(3, 4, 10'h0A0, 10'h1C0, 1);
    drive_pass(3, 4, 10'h0A0, 10'h1C0, 1, 2);
    for (int c = 0; c < exp_q.size(); c++) begin
      n_cmp++;
      if (obs_q[c] !== exp_q[c]) begin
        n_bad++;
        $display("FAIL restart cyc %0d: got %h want %h",
                 c, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_random();
    int n, k;
    logic [9:0] rd, wr;
    bit norm;
    for (int it = 0; it < 20; it++) begin
      n    = $urandom_range(0, 5);
      k    = $urandom_range(0, 5);
      rd   = 10'($urandom);
      wr   = 10'($urandom);
      norm = 1'($urandom);
      for (int i = 0; i < MAXC; i++)
        stall_pat[i] = ($urandom_range(0, 9) < 3);
      build_model(n, k, rd, wr, norm);
      drive_pass(n, k, rd, wr, norm, -1);
      for (int c = 0; c < exp_q.size(); c++) begin
        n_cmp++;
        if (obs_q[c] !== exp_q[c]) begin
          n_bad++;
          $display("FAIL rand%0d cyc %0d: got %h want %h",
                   it, c, obs_q[c], exp_q[c]);
        end
      end
    end
    clear_stall();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ext_write_req = 1'b0;
    bus.cfg_num_out = '0;
    bus.cfg_kernel_size = '0;
    bus.cfg_rd_base = '0;
    bus.cfg_wr_base = '0;
    bus.cfg_norm_en = 1'b0;
    clear_stall();
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_n_zero();
    test_k_zero();
    test_norm();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
